// File: rtl/bank_req_scheduler.sv
// rtl/bank_req_scheduler.sv - per-bank descriptor FIFOs with a round-robin single-issue output register
module bank_req_scheduler #(
  parameter int BANKS = 16,
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [0:BANKS-1][IDX_W+1:0] in_req,
  output logic                        out_busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(BANKS)-1:0]    out_bank,
  output logic                        out_type,
  output logic [IDX_W-1:0]            out_index,
  output logic                        overflow
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(DEPTH - 1);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;

  logic [PTR_W-1:0]  wptr  [BANKS];
  logic [PTR_W-1:0]  rptr  [BANKS];
  logic [CNT_W-1:0]  count [BANKS];
  logic [IDX_W:0]    mem   [BANKS][DEPTH];
  logic [BANK_W-1:0] rr_ptr;

  logic [BANKS-1:0]  nonempty, push, pop, drop;
  logic              grant_vld, pop_en;
  logic [BANK_W-1:0] grant, cand;

  always_comb begin
    out_busy = 1'b0;
    nonempty = '0;
    for (int b = 0; b < BANKS; b++) begin
      nonempty[b] = (count[b] != '0);
      if (count[b] >= BUSY_LVL) out_busy = 1'b1;
    end
  end

  // Round-robin search starting at rr_ptr; BANKS is a power of two so index wrap is free.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 0; k < BANKS; k++) begin
      cand = rr_ptr + BANK_W'(k);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  assign pop_en = grant_vld && ((state == IDLE) || out_ready);

  always_comb begin
    push = '0;
    pop  = '0;
    drop = '0;
    for (int b = 0; b < BANKS; b++) begin
      pop[b]  = pop_en && (grant == BANK_W'(b));
      push[b] = in_req[b][IDX_W+1] && ((count[b] != FULL) || pop[b]);
      drop[b] = in_req[b][IDX_W+1] && !((count[b] != FULL) || pop[b]);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++)
      if (push[b]) mem[b][wptr[b]] <= in_req[b][IDX_W:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BANKS; b++) begin
        wptr[b]  <= '0;
        rptr[b]  <= '0;
        count[b] <= '0;
      end
      rr_ptr    <= '0;
      state     <= IDLE;
      out_valid <= 1'b0;
      out_bank  <= '0;
      out_type  <= 1'b0;
      out_index <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (push[b]) wptr[b] <= wptr[b] + 1'b1;
        if (pop[b])  rptr[b] <= rptr[b] + 1'b1;
        if (push[b] && !pop[b])      count[b] <= count[b] + 1'b1;
        else if (!push[b] && pop[b]) count[b] <= count[b] - 1'b1;
      end
      if (|drop) overflow <= 1'b1;
      if (pop_en) begin
        out_bank               <= grant;
        {out_type, out_index}  <= mem[grant][rptr[grant]];
        rr_ptr                 <= grant + 1'b1;
      end
      case (state)
        IDLE: if (grant_vld) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready && !grant_vld) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bank_req_scheduler.sv
// tb/tb_bank_req_scheduler.sv - scoreboard bench for bank_req_scheduler
module tb_bank_req_scheduler;
  logic            clk;
  logic            rst;
  logic [0:15][7:0] in_req;
  logic            out_busy, out_valid, out_ready, out_type, overflow;
  logic [3:0]      out_bank;
  logic [5:0]      out_index;

  typedef struct {
    logic [3:0] bank;
    logic       typ;
    logic [5:0] idx;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] order_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  bank_req_scheduler #(.BANKS(16), .DEPTH(4), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .out_busy(out_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
    .out_type(out_type), .out_index(out_index), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int bank, input logic typ, input int idx, input bit ok);
    exp_t e;
    in_req[bank] = {1'b1, typ, 6'(idx)};
    e.bank = 4'(bank);
    e.typ  = typ;
    e.idx  = 6'(idx);
    if (ok) sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_left", sb.size(), 0);
    tick();
    check_eq("drain_idle", out_valid, 0);
    check_eq("order_left", order_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_req = '0;
    out_ready = 1'b0;
    sb.delete();
    order_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Descriptors are sampled on the falling edge ahead of the handshake edge.
  always @(negedge clk) begin
    int hit;
    if (rst && out_valid && out_ready) begin
      hit = -1;
      for (int i = 0; i < sb.size(); i++)
        if (hit < 0 && sb[i].bank == out_bank) hit = i;
      if (hit < 0) check_eq("unexpected_issue", 1, 0);
      else begin
        check_eq("issue_type", out_type, sb[hit].typ);
        check_eq("issue_index", out_index, sb[hit].idx);
        sb.delete(hit);
      end
      if (order_q.size() > 0) begin
        check_eq("issue_bank", out_bank, order_q[0]);
        void'(order_q.pop_front());
      end
    end
  end

  initial begin
    int n, cyc;
    rst = 1'b0;
    out_ready = 1'b0;
    in_req = '0;
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_bank", out_bank, 0);
    check_eq("rst_type", out_type, 0);
    check_eq("rst_index", out_index, 0);
    check_eq("rst_busy", out_busy, 0);
    check_eq("rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // single descriptor latency
    out_ready = 1'b1;
    push(5, 1'b0, 3, 1);
    tick();
    in_req = '0;
    check_eq("lat_not_yet", out_valid, 0);
    tick();
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_bank", out_bank, 5);
    check_eq("lat_type", out_type, 0);
    check_eq("lat_index", out_index, 3);
    tick();
    check_eq("lat_idle", out_valid, 0);

    // round-robin from rr_ptr = 0
    do_reset();
    out_ready = 1'b1;
    push(0, 1'b0, 1, 1);
    push(3, 1'b1, 2, 1);
    push(15, 1'b0, 4, 1);
    order_q = '{4'd0, 4'd3, 4'd15};
    tick();
    in_req = '0;
    drain();
    out_ready = 1'b0;
    push(0, 1'b0, 11, 1);
    tick();
    in_req = '0;
    tick();
    push(0, 1'b1, 12, 1);
    push(2, 1'b0, 13, 1);
    order_q = '{4'd0, 4'd2, 4'd0};
    tick();
    in_req = '0;
    drain();

    // held output stays stable
    out_ready = 1'b0;
    push(9, 1'b1, 10, 1);
    tick();
    in_req = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_bank", out_bank, 9);
      check_eq("hold_type", out_type, 1);
      check_eq("hold_index", out_index, 10);
    end
    out_ready = 1'b1;
    tick();
    check_eq("handoff_one_cycle", out_valid, 0);
    check_eq("handoff_sb", sb.size(), 0);

    // busy threshold, full FIFO and drop
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      push(2, 1'b1, 19 + k, k <= 5);
      tick();
      in_req = '0;
      check_eq("busy_after_push", out_busy, (k >= 4) ? 1 : 0);
      check_eq("ovf_after_push", overflow, (k == 6) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ovf_sticky", overflow, 1);
    end
    drain();
    check_eq("busy_cleared", out_busy, 0);
    check_eq("ovf_kept", overflow, 1);

    // in-order issue through pointer wrap with toggling ready
    do_reset();
    n = 0;
    cyc = 0;
    while (n < 12 && cyc < 200) begin
      out_ready = ~out_ready;
      if (!out_busy) begin
        push(7, 1'b0, n, 1);
        n++;
      end
      tick();
      in_req = '0;
      cyc++;
    end
    check_eq("wrap_pushes", n, 12);
    drain();
    check_eq("wrap_no_ovf", overflow, 0);

    // full FIFO: push and pop in the same cycle
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(7, 1'b1, 40 + k, 1);
      tick();
      in_req = '0;
    end
    check_eq("full_busy", out_busy, 1);
    out_ready = 1'b1;
    push(7, 1'b1, 45, 1);
    tick();
    in_req = '0;
    check_eq("same_cycle_no_ovf", overflow, 0);
    check_eq("same_cycle_busy", out_busy, 1);
    drain();
    check_eq("same_cycle_ovf_end", overflow, 0);

    // asynchronous reset while holding
    out_ready = 1'b0;
    push(1, 1'b0, 7, 1);
    push(4, 1'b1, 8, 1);
    push(8, 1'b0, 9, 1);
    tick();
    in_req = '0;
    tick();
    check_eq("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    sb.delete();
    order_q.delete();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_valid", out_valid, 0);
    end
    check_eq("post_rst_bank", out_bank, 0);
    check_eq("post_rst_type", out_type, 0);
    check_eq("post_rst_index", out_index, 0);
    check_eq("post_rst_busy", out_busy, 0);
    check_eq("post_rst_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
